// File: rtl/cdm8_err_monitor.sv
// Sweeps all 65536 (A,B) pairs through an attached 8x8 approximate multiplier and accumulates error stats.
// 3-stage capture/diff/accumulate pipeline; hold freezes the sweep in SWEEP and inserts bubbles.
`timescale 1ns/1ps
module cdm8_err_monitor (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        hold,
  output logic [7:0]  a_out,
  output logic [7:0]  b_out,
  input  logic [15:0] r_in,
  output logic        busy,
  output logic        done,
  output logic [16:0] err_count,
  output logic [31:0] sum_err,
  output logic [15:0] med,
  output logic [15:0] max_err,
  output logic [7:0]  max_a,
  output logic [7:0]  max_b
);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] cnt;
  logic        drain_cnt;
  logic        launch, capture, last_cap;

  logic        s0_vld;
  logic [7:0]  s0_a, s0_b;
  logic [15:0] s0_r;
  logic        s1_vld;
  logic [7:0]  s1_a, s1_b;
  logic [15:0] s1_diff;
  logic [15:0] prod;
  logic [15:0] diff;

  assign launch   = start && (state == IDLE || state == DONE);
  assign capture  = (state == SWEEP) && !hold;
  assign last_cap = capture && (cnt == 16'hFFFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (launch)    state_nxt = SWEEP;
      SWEEP:      if (last_cap)  state_nxt = DRAIN;
      DRAIN:      if (drain_cnt) state_nxt = DONE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // Two DRAIN cycles flush stages 1 and 2 before results are declared stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                drain_cnt <= 1'b0;
    else if (state == DRAIN)   drain_cnt <= ~drain_cnt;
    else                       drain_cnt <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt <= 16'h0000;
    else if (launch)  cnt <= 16'h0000;
    else if (capture) cnt <= cnt + 16'h0001;
  end

  assign a_out = cnt[15:8];
  assign b_out = cnt[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_vld <= 1'b0;
      s0_a   <= 8'h00;
      s0_b   <= 8'h00;
      s0_r   <= 16'h0000;
    end else begin
      s0_vld <= capture;
      if (capture) begin
        s0_a <= cnt[15:8];
        s0_b <= cnt[7:0];
        s0_r <= r_in;
      end
    end
  end

  // Unsigned magnitude compare avoids any signed wrap in the distance.
  assign prod = s0_a * s0_b;
  assign diff = (prod >= s0_r) ? (prod - s0_r) : (s0_r - prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_a    <= 8'h00;
      s1_b    <= 8'h00;
      s1_diff <= 16'h0000;
    end else begin
      s1_vld <= s0_vld;
      if (s0_vld) begin
        s1_a    <= s0_a;
        s1_b    <= s0_b;
        s1_diff <= diff;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= 17'd0;
      sum_err   <= 32'd0;
      max_err   <= 16'd0;
      max_a     <= 8'h00;
      max_b     <= 8'h00;
    end else if (launch) begin
      err_count <= 17'd0;
      sum_err   <= 32'd0;
      max_err   <= 16'd0;
      max_a     <= 8'h00;
      max_b     <= 8'h00;
    end else if (s1_vld) begin
      err_count <= err_count + {16'd0, (s1_diff != 16'd0)};
      sum_err   <= sum_err + {16'd0, s1_diff};
      // Strictly greater keeps the earliest pair on ties.
      if (s1_diff > max_err) begin
        max_err <= s1_diff;
        max_a   <= s1_a;
        max_b   <= s1_b;
      end
    end
  end

  assign med  = sum_err[31:16];
  assign busy = (state == SWEEP) || (state == DRAIN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_cdm8_err_monitor.sv
// Drives a randomised faulty multiplier table into cdm8_err_monitor and checks statistics against a direct sum over all pairs.
`timescale 1ns/1ps
module tb_cdm8_err_monitor;

  logic        clk = 1'b0;
  logic        rst_n, start, hold;
  logic [7:0]  a_out, b_out;
  logic [15:0] r_in;
  logic        busy, done;
  logic [16:0] err_count;
  logic [31:0] sum_err;
  logic [15:0] med, max_err;
  logic [7:0]  max_a, max_b;

  logic [15:0] lut [65536];
  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  assign r_in = lut[{a_out, b_out}];

  cdm8_err_monitor dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hold(hold),
    .a_out(a_out), .b_out(b_out), .r_in(r_in),
    .busy(busy), .done(done), .err_count(err_count), .sum_err(sum_err),
    .med(med), .max_err(max_err), .max_a(max_a), .max_b(max_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_chk++;
    assert (obs === want) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
  endtask

  // Direct statistics over pairs 0..upto-1 in sweep order.
  task automatic model(input int upto, output int ec, output longint es,
                       output int me, output int ma, output int mb);
    ec = 0; es = 0; me = 0; ma = 0; mb = 0;
    for (int k = 0; k < upto; k++) begin
      int p, d;
      p = (k / 256) * (k % 256);
      d = p - int'(lut[k]);
      if (d < 0) d = -d;
      if (d != 0) ec++;
      es += longint'(d);
      if (d > me) begin me = d; ma = k / 256; mb = k % 256; end
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_ab"},   {a_out, b_out}, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_ecnt"}, err_count, 0);
    chk({pfx, "_sum"},  sum_err, 0);
    chk({pfx, "_med"},  med, 0);
    chk({pfx, "_max"},  max_err, 0);
    chk({pfx, "_maxab"}, {max_a, max_b}, 0);
  endtask

  initial begin
    int     f_ec, f_me, f_ma, f_mb, p_ec, p_me, p_ma, p_mb;
    longint f_es, p_es;
    int     guard, edges, hold_left;
    bit     hold_done, frz_chk, ign;
    logic [15:0] cnt;

    rst_n = 1'b0; start = 1'b0; hold = 1'b0;
    for (int k = 0; k < 65536; k++) begin
      logic [15:0] p;
      p = 16'((k / 256) * (k % 256));
      lut[k] = ($urandom_range(0, 1) == 1) ? (p ^ 16'($urandom_range(0, 255))) : p;
    end
    // Three pairs share the largest distance; the earliest (0,5) must win.
    lut[16'h0005] = 16'd65025;
    lut[16'h8001] = 16'd65153;
    lut[16'hFFFF] = 16'd0;
    model(65536, f_ec, f_es, f_me, f_ma, f_mb);
    model(16'h003E, p_ec, p_es, p_me, p_ma, p_mb);

    #12;
    chk_zero("reset");
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;

    // Partial sweep: with the counter showing 0x0040, pairs 0..0x3D have been accumulated.
    guard = 0;
    while ({a_out, b_out} != 16'h0040 && guard < 1000) begin
      @(negedge clk); guard++;
    end
    chk("part_reach", {a_out, b_out}, 16'h0040);
    chk("part_ecnt", err_count, p_ec);
    chk("part_sum", sum_err, p_es);
    chk("part_max", max_err, p_me);
    chk("part_maxab", {max_a, max_b}, {p_ma[7:0], p_mb[7:0]});
    #2 rst_n = 1'b0;
    #1 chk_zero("midrst");
    @(negedge clk); rst_n = 1'b1;

    // Full sweep with a 10-cycle stall, an ignored start and a hold during drain.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("go_ab", {a_out, b_out}, 0);
    chk("go_busy", busy, 1);
    chk("go_done", done, 0);
    edges = 0; hold_left = 0; hold_done = 0; frz_chk = 0; ign = 0;
    while (!done && edges < 70000) begin
      cnt = {a_out, b_out};
      if (!hold_done && cnt == 16'h1234) begin
        hold_done = 1; hold_left = 10;
      end else if (hold_done && hold_left == 0 && !frz_chk) begin
        frz_chk = 1;
        chk("hold_freeze", cnt, 16'h1234);
      end
      hold = (hold_left > 0) || (edges == 65546);
      if (hold_left > 0) hold_left--;
      start = (cnt == 16'h8000) && !ign;
      if (start) ign = 1;
      if (edges == 65547) chk("busy_pre_done", busy, 1);
      @(negedge clk); edges++;
    end
    start = 1'b0; hold = 1'b0;
    chk("done_latency", edges, 65548);
    chk("done_flag", done, 1);
    chk("done_busy", busy, 0);
    chk("ign_start_seen", ign, 1);
    chk("fin_ecnt", err_count, f_ec);
    chk("fin_sum", sum_err, f_es);
    chk("fin_med", med, f_es >> 16);
    chk("fin_max", max_err, f_me);
    chk("fin_maxab", {max_a, max_b}, {f_ma[7:0], f_mb[7:0]});

    repeat (5) @(negedge clk);
    chk("hold_done", done, 1);
    chk("hold_sum", sum_err, f_es);
    chk("hold_ecnt", err_count, f_ec);

    start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("re_done", done, 0);
    chk("re_busy", busy, 1);
    chk("re_ab", {a_out, b_out}, 0);
    chk("re_ecnt", err_count, 0);
    chk("re_sum", sum_err, 0);
    chk("re_max", max_err, 0);
    chk("re_maxab", {max_a, max_b}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
